// File: rtl/imem_boot_loader.sv
// imem_boot_loader
//
// Loads a program image into instruction memory from a byte stream. The
// processor is held in reset while loading and is released only after the
// final word has been written.
//
// Stream layout: word count N (2 bytes, high byte first), then 4*N payload
// bytes with each word sent MSB first. When LOADER_CHECKSUM_EN is defined,
// one more byte follows: the XOR of all payload bytes (header excluded).
//
// Optional feature macro: LOADER_CHECKSUM_EN (adds the CHK state and the
// running XOR accumulator).
//
// Handshake: a byte moves when in_valid && in_ready are both high at a rising
// edge of clk. in_ready does not depend on in_valid. The producer must hold
// in_data stable while in_valid is high and in_ready is low.
//
// Ports:
//   clk, rst      - system clock; synchronous active-high reset
//   in_data       - stream byte
//   in_valid      - in_data is valid
//   in_ready      - loader accepts a byte this cycle
//   reload        - restart request, honoured only in DONE or ERR
//   imem_we       - one-cycle instruction-memory write strobe
//   imem_addr     - word address of the write
//   imem_wdata    - word to write
//   cpu_rst       - processor reset, high unless the load completed
//   busy          - header, payload or checksum phase in progress
//   done          - load completed successfully
//   err           - load aborted (oversize count or checksum mismatch)
//   state_dbg     - current FSM state encoding
module imem_boot_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              reload,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [2:0]        state_dbg
);

    typedef enum logic [2:0] {
        S_HDR_HI = 3'd0,
        S_HDR_LO = 3'd1,
        S_LOAD   = 3'd2,
`ifdef LOADER_CHECKSUM_EN
        S_CHK    = 3'd3,
`endif
        S_DONE   = 3'd4,
        S_ERR    = 3'd5
    } state_t;

    // State entered once the payload is complete (also for N = 0).
`ifdef LOADER_CHECKSUM_EN
    localparam state_t S_AFTER = S_CHK;
`else
    localparam state_t S_AFTER = S_DONE;
`endif

    // Capacity in words; one extra bit so 2^ADDR_W itself is representable.
    localparam logic [16:0] CAP = 17'(1) << ADDR_W;

    state_t              state, state_n;
    logic [15:0]         count, count_n;
    logic [15:0]         wcnt, wcnt_n;
    logic [1:0]          bidx, bidx_n;
    logic [23:0]         shreg, shreg_n;
    logic                fin, fin_n;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]          csum, csum_n;
`endif

    logic                ready_n, we_n, cpu_rst_n, busy_n, done_n, err_n;
    logic [ADDR_W-1:0]   addr_n;
    logic [31:0]         wdata_n;

    logic                xfer;
    logic [15:0]         hdr_n;
    logic [31:0]         word;

    assign xfer      = in_valid && in_ready;
    assign hdr_n     = {count[15:8], in_data};
    assign word      = {shreg, in_data};
    assign state_dbg = state;

    always_comb begin
        state_n = state;
        count_n = count;
        wcnt_n  = wcnt;
        bidx_n  = bidx;
        shreg_n = shreg;
        fin_n   = fin;
`ifdef LOADER_CHECKSUM_EN
        csum_n  = csum;
`endif
        we_n    = 1'b0;
        addr_n  = imem_addr;
        wdata_n = imem_wdata;

        case (state)
            S_HDR_HI: begin
                if (xfer) begin
                    count_n = {in_data, count[7:0]};
                    state_n = S_HDR_LO;
                end
            end
            S_HDR_LO: begin
                if (xfer) begin
                    count_n = hdr_n;
                    wcnt_n  = 16'd0;
                    bidx_n  = 2'd0;
                    fin_n   = 1'b0;
                    if (hdr_n == 16'd0) begin
                        state_n = S_AFTER;
                    end else if ({1'b0, hdr_n} > CAP) begin
                        state_n = S_ERR;
                    end else begin
                        state_n = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                // fin marks the cycle in which the last word is being written;
                // leaving LOAD one cycle later keeps the release strictly after
                // the final write strobe.
                if (fin) begin
                    fin_n   = 1'b0;
                    state_n = S_AFTER;
                end else if (xfer) begin
                    shreg_n = word[23:0];
                    bidx_n  = bidx + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                    csum_n  = csum ^ in_data;
`endif
                    if (bidx == 2'd3) begin
                        we_n    = 1'b1;
                        addr_n  = wcnt[ADDR_W-1:0];
                        wdata_n = word;
                        wcnt_n  = wcnt + 16'd1;
                        if (wcnt == count - 16'd1) begin
                            fin_n = 1'b1;
                        end
                    end
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHK: begin
                if (xfer) begin
                    state_n = (in_data == csum) ? S_DONE : S_ERR;
                end
            end
`endif
            S_DONE, S_ERR: begin
                if (reload) begin
                    state_n = S_HDR_HI;
                    count_n = 16'd0;
                    wcnt_n  = 16'd0;
                    bidx_n  = 2'd0;
                    shreg_n = 24'd0;
                    fin_n   = 1'b0;
`ifdef LOADER_CHECKSUM_EN
                    csum_n  = 8'd0;
`endif
                end
            end
            default: begin
                state_n = S_HDR_HI;
            end
        endcase

        // Outputs are registered from the next state so they line up with it.
        ready_n = (state_n == S_HDR_HI) || (state_n == S_HDR_LO) ||
                  ((state_n == S_LOAD) && !fin_n);
`ifdef LOADER_CHECKSUM_EN
        if (state_n == S_CHK) begin
            ready_n = 1'b1;
        end
`endif
        busy_n    = (state_n != S_DONE) && (state_n != S_ERR);
        done_n    = (state_n == S_DONE);
        err_n     = (state_n == S_ERR);
        cpu_rst_n = (state_n != S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_HDR_HI;
            count      <= 16'd0;
            wcnt       <= 16'd0;
            bidx       <= 2'd0;
            shreg      <= 24'd0;
            fin        <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum       <= 8'd0;
`endif
            in_ready   <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= 32'd0;
            cpu_rst    <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_n;
            count      <= count_n;
            wcnt       <= wcnt_n;
            bidx       <= bidx_n;
            shreg      <= shreg_n;
            fin        <= fin_n;
`ifdef LOADER_CHECKSUM_EN
            csum       <= csum_n;
`endif
            in_ready   <= ready_n;
            imem_we    <= we_n;
            imem_addr  <= addr_n;
            imem_wdata <= wdata_n;
            cpu_rst    <= cpu_rst_n;
            busy       <= busy_n;
            done       <= done_n;
            err        <= err_n;
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Testbench for imem_boot_loader (ADDR_W = 2, capacity 4 words).
// Stimulus builds byte streams; a reference model derives the expected
// memory writes and final outcome from the stream, and a monitor pops the
// expected writes whenever the loader strobes imem_we.
module tb_imem_boot_loader;
  localparam int ADDR_W = 2;
  localparam int CAP = 1 << ADDR_W;
`ifdef LOADER_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic              clk;
  logic              rst;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              reload;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_rst;
  logic              busy;
  logic              done;
  logic              err;
  logic [2:0]        state_dbg;

  imem_boot_loader #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .reload     (reload),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_rst    (cpu_rst),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .state_dbg  (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  logic [ADDR_W+31:0] exp_q[$];
  int                 exp_t_q[$];
  logic [7:0]         stream[$];
  logic [31:0]        words[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst) begin
      check("cpu_rst_vs_done", {63'd0, cpu_rst}, {63'd0, !done});
      if (imem_we) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write: addr=%0h data=%0h, no write expected", imem_addr, imem_wdata);
        end else begin
          check("write", {30'd0, imem_addr, imem_wdata}, {30'd0, exp_q.pop_front()});
        end
        if (exp_t_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write_time: cycle=%0d, no write time expected", cyc);
        end else begin
          check("write_cycle", 64'(cyc), 64'(exp_t_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #(200000 * 10);
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // reference model: expected writes and outcome, straight from the stream rules
  task automatic model_expect(output bit exp_done, output int nwords);
    int n;
    logic [7:0] x;
    n = int'(stream[0]) * 256 + int'(stream[1]);
    nwords = 0;
    exp_done = 1'b0;
    if (n > CAP) return;
    x = 8'd0;
    for (int w = 0; w < n; w++) begin
      logic [31:0] wd;
      wd = {stream[2+4*w], stream[3+4*w], stream[4+4*w], stream[5+4*w]};
      exp_q.push_back({ADDR_W'(w), wd});
      x = x ^ wd[31:24] ^ wd[23:16] ^ wd[15:8] ^ wd[7:0];
    end
    nwords = n;
    if (CHK_EN) exp_done = (stream[2+4*n] == x);
    else exp_done = 1'b1;
  endtask

  task automatic make_stream(input int n, input logic [7:0] flip);
    logic [7:0] x;
    stream.delete();
    stream.push_back(8'(n >> 8));
    stream.push_back(8'(n));
    if (n > CAP) return;
    x = 8'd0;
    for (int w = 0; w < n; w++) begin
      for (int b = 3; b >= 0; b--) begin
        logic [7:0] by;
        by = 8'(words[w] >> (8 * b));
        stream.push_back(by);
        x = x ^ by;
      end
    end
    if (CHK_EN) stream.push_back(x ^ flip);
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // driver: called at posedge+1; returns at posedge+1 after the transfer
  task automatic send_byte(input logic [7:0] b, input int gap, input bit chk_stall,
                           input bit noise, output int xc, output bit ok);
    logic [2:0] st0;
    if (gap > 0) begin
      in_valid = 1'b0;
      st0 = state_dbg;
      repeat (gap) begin
        @(posedge clk);
        #1;
        if (chk_stall) check("stall_state", {61'd0, state_dbg}, {61'd0, st0});
      end
    end
    in_data = b;
    in_valid = 1'b1;
    reload = noise && ($urandom_range(0, 3) == 0);
    ok = 1'b0;
    xc = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      xc = cyc + 1;
      @(posedge clk);
      #1;
    end else begin
      total++;
      bad++;
      $display("FAIL ready_timeout: in_ready low for 100 cycles, byte %0h", b);
    end
    in_valid = 1'b0;
    reload = 1'b0;
  endtask

  task automatic run_load(input int gap_lo, input int gap_hi, input bit noise);
    bit exp_done;
    int nw;
    int last_x;
    int xc;
    bit ok;
    int exp_end;
    sync();
    model_expect(exp_done, nw);
    last_x = 0;
    ok = 1'b1;
    for (int i = 0; i < stream.size() && ok; i++) begin
      int g;
      g = (i == 0) ? 0 : $urandom_range(gap_lo, gap_hi);
      send_byte(stream[i], g, (i > 0) && (i < 2 + 4 * nw), noise, xc, ok);
      if (ok && i >= 2 && i < 2 + 4 * nw && ((i - 2) % 4) == 3) exp_t_q.push_back(xc);
      last_x = xc;
    end
    exp_end = (nw > 0 && !CHK_EN) ? last_x + 1 : last_x;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done || err) break;
    end
    check("end_cycle", 64'(cyc), 64'(exp_end));
    check("done", {63'd0, done}, {63'd0, exp_done});
    check("err", {63'd0, err}, {63'd0, !exp_done});
    check("end_cpu_rst", {63'd0, cpu_rst}, {63'd0, !exp_done});
    check("end_busy", {63'd0, busy}, 64'd0);
    check("end_in_ready", {63'd0, in_ready}, 64'd0);
    check("writes_left", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    exp_t_q.delete();
  endtask

  task automatic do_reload();
    sync();
    reload = 1'b1;
    @(posedge clk);
    #1;
    reload = 1'b0;
    @(negedge clk);
    check("reload_in_ready", {63'd0, in_ready}, 64'd1);
    check("reload_busy", {63'd0, busy}, 64'd1);
    check("reload_cpu_rst", {63'd0, cpu_rst}, 64'd1);
    check("reload_done", {63'd0, done}, 64'd0);
    check("reload_err", {63'd0, err}, 64'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"}, {63'd0, in_ready}, 64'd0);
    check({tag, "_imem_we"}, {63'd0, imem_we}, 64'd0);
    check({tag, "_imem_addr"}, {62'd0, imem_addr}, 64'd0);
    check({tag, "_imem_wdata"}, {32'd0, imem_wdata}, 64'd0);
    check({tag, "_cpu_rst"}, {63'd0, cpu_rst}, 64'd1);
    check({tag, "_busy"}, {63'd0, busy}, 64'd0);
    check({tag, "_done"}, {63'd0, done}, 64'd0);
    check({tag, "_err"}, {63'd0, err}, 64'd0);
  endtask

  task automatic set_prog();
    words.delete();
    words.push_back(32'h014A4820);
    words.push_back(32'h01286022);
    words.push_back(32'h8D090004);
  endtask

  task automatic set_random(input int n);
    words.delete();
    for (int w = 0; w < n; w++) words.push_back($urandom);
  endtask

  initial begin
    int xc;
    bit ok;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 8'd0;
    reload = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("ready_before_edge", {63'd0, in_ready}, 64'd0);
    @(negedge clk);
    check("ready_after_edge", {63'd0, in_ready}, 64'd1);
    check("busy_after_edge", {63'd0, busy}, 64'd1);

    // three-word program, continuous stream
    set_prog();
    make_stream(3, 8'd0);
    run_load(0, 0, 1'b0);

    // bytes offered in DONE are ignored
    sync();
    in_data = 8'hA5;
    in_valid = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("done_hold", {63'd0, done}, {63'd0, !CHK_EN || 1'b1});
    check("done_in_ready", {63'd0, in_ready}, 64'd0);

    // same program with 3-cycle gaps between bytes
    do_reload();
    make_stream(3, 8'd0);
    run_load(3, 3, 1'b0);

    // oversize header
    do_reload();
    make_stream(CAP + 1, 8'd0);
    run_load(0, 0, 1'b0);

    // reload out of ERR, full-capacity image
    do_reload();
    set_random(CAP);
    make_stream(CAP, 8'd0);
    run_load(0, 2, 1'b1);

    // empty image
    do_reload();
    make_stream(0, 8'd0);
    run_load(0, 0, 1'b0);

    // single DEADBEEF word after reload
    do_reload();
    words.delete();
    words.push_back(32'hDEADBEEF);
    make_stream(1, 8'd0);
    run_load(0, 0, 1'b0);

`ifdef LOADER_CHECKSUM_EN
    do_reload();
    words.delete();
    words.push_back(32'h12345678);
    make_stream(1, 8'd0);
    check("csum_byte", {56'd0, stream[6]}, 64'h08);
    run_load(0, 0, 1'b0);
    do_reload();
    make_stream(1, 8'h01);
    run_load(0, 0, 1'b0);
`endif

    // reset after two payload bytes, then a full load from address 0
    do_reload();
    sync();
    set_prog();
    make_stream(3, 8'd0);
    for (int i = 0; i < 4; i++) send_byte(stream[i], 0, 1'b0, 1'b0, xc, ok);
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check_reset_vals("midrst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    set_random(2);
    make_stream(2, 8'd0);
    run_load(0, 1, 1'b0);

    // randomized images, gaps and ignored reload pulses
    for (int it = 0; it < 12; it++) begin
      int n;
      logic [7:0] flip;
      n = $urandom_range(0, CAP + 1);
      flip = (CHK_EN && $urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
      do_reload();
      set_random(n);
      make_stream(n, flip);
      run_load(0, $urandom_range(0, 3), 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
